dmem_access_ctrl: RTL

// - Sequences one data-memory access at a time for the Memory stage.
// - Accepts a load/store op, drives a valid/ready request to dmem and waits for the response.
// - Formats load data (lane select, sign/zero extend) and raises stall while the access is outstanding.
// - Sits between the X->M pipeline boundary and the dmem port; its stall feeds M_stage stall_in.

---
 rtl/dmem_access_ctrl_pkg.sv | 53 +++++
 rtl/dmem_access_ctrl_if.sv | 32 +++
 rtl/dmem_access_ctrl_lane_fmt.sv | 51 +++++
 rtl/dmem_access_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg
//   Shared types and helpers for the Memory-stage data-memory access controller.
//   - N_BITS             address/data width (only 32 is supported)
//   - mem_size_t         access size encoding carried on op_size
//   - dmem_ctrl_state_t  controller states IDLE, REQ, WAIT, RESP
//   - mem_op_t           op fields captured when an access is accepted
//   - lane_of()          byte lane of the access within the 32-bit word
//   - is_misaligned()    natural-alignment test used when DMEM_MISALIGN_CHK_EN is defined
package dmem_access_ctrl_pkg;

    localparam int N_BITS = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } dmem_ctrl_state_t;

    typedef struct packed {
        logic              wr;
        mem_size_t         size;
        logic              uns;
        logic [N_BITS-1:0] addr;
        logic [N_BITS-1:0] wdata;
    } mem_op_t;

    // Half accesses snap to lane 0 or 2 and word accesses to lane 0, so a
    // misaligned address never selects bytes outside the addressed word.
    // The undefined encoding 2'b11 behaves as a word.
    function automatic logic [1:0] lane_of(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if
//   Data-memory request/response port between the access controller and dmem.
//   - dmem_req_vld/rdy   request handshake; valid stays up until ready
//   - dmem_req_we        1 = store
//   - dmem_req_addr      word-aligned byte address
//   - dmem_req_be        byte enables
//   - dmem_req_wdata     lane-replicated store data
//   - dmem_rsp_vld/data  response pulse and raw read word
//   Modports: master = controller side, slave = memory side.
interface dmem_access_ctrl_if;
    import dmem_access_ctrl_pkg::*;

    logic              dmem_req_vld;
    logic              dmem_req_rdy;
    logic              dmem_req_we;
    logic [N_BITS-1:0] dmem_req_addr;
    logic [3:0]        dmem_req_be;
    logic [N_BITS-1:0] dmem_req_wdata;
    logic              dmem_rsp_vld;
    logic [N_BITS-1:0] dmem_rsp_data;

    modport master (
        output dmem_req_vld, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata,
        input  dmem_req_rdy, dmem_rsp_vld, dmem_rsp_data
    );

    modport slave (
        input  dmem_req_vld, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata,
        output dmem_req_rdy, dmem_rsp_vld, dmem_rsp_data
    );

endinterface

// File: rtl/dmem_access_ctrl_lane_fmt.sv
// dmem_access_ctrl_lane_fmt
//   Combinational lane handling for one data-memory access.
//   - size_i, uns_i, addr_lo_i  access size, zero-extend flag, address bits [1:0]
//   - wdata_i                   LSB-aligned store data
//   - rdata_i                   raw word returned by dmem
//   - be_o                      byte enables for the addressed lane(s)
//   - wdata_o                   store data replicated across all lanes
//   - rdata_o                   selected lane, sign- or zero-extended
module dmem_access_ctrl_lane_fmt
    import dmem_access_ctrl_pkg::*;
(
    input  mem_size_t         size_i,
    input  logic              uns_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [N_BITS-1:0] wdata_i,
    input  logic [N_BITS-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [N_BITS-1:0] wdata_o,
    output logic [N_BITS-1:0] rdata_o
);

    logic [1:0]        lane;
    logic [N_BITS-1:0] shifted;
    logic              sext;

    assign lane    = lane_of(size_i, addr_lo_i);
    assign shifted = rdata_i >> {lane, 3'b000};
    assign sext    = ~uns_i;

    always_comb begin
        // NOTE: every output is given a default before the case so that no
        // path through the block leaves a value unassigned (no latch).
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (size_i)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << lane;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{(N_BITS-8){sext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                be_o    = 4'b0011 << lane;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{(N_BITS-16){sext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequences one data-memory access at a time for the Memory stage: accepts a
//   load/store, issues a valid/ready request to dmem, waits for the response,
//   formats load data and holds the upstream pipeline while busy.
//   Ports:
//   - clk, rst_n          core clock, asynchronous active-low reset
//   - op_vld / op_rdy     op offer / controller idle
//   - op_wr, op_size, op_unsigned, op_addr, op_wdata   op fields
//   - squash_in           kills the offered or in-flight op (no response pulse)
//   - dmem                dmem_access_ctrl_if master port
//   - rsp_vld             1-cycle completion pulse
//   - rsp_data            formatted load data (0 for stores and errors)
//   - rsp_err             timeout or misaligned access
//   - rsp_misalign        misaligned access
//   - stall               hold upstream pipeline
//   Parameter TIMEOUT_CYCLES: WAIT cycles without a response before aborting.
//   Build option: define DMEM_MISALIGN_CHK_EN to reject misaligned half/word
//   accesses without touching dmem.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      op_vld,
    output logic                      op_rdy,
    input  logic                      op_wr,
    input  logic [1:0]                op_size,
    input  logic                      op_unsigned,
    input  logic [N_BITS-1:0]         op_addr,
    input  logic [N_BITS-1:0]         op_wdata,
    input  logic                      squash_in,
    dmem_access_ctrl_if.master        dmem,
    output logic                      rsp_vld,
    output logic [N_BITS-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      rsp_misalign,
    output logic                      stall
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_ctrl_state_t  state_q;
    mem_op_t           op_q;
    mem_op_t           op_d;
    logic              kill_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_vld_q;
    logic              rsp_vld_q;
    logic              rsp_err_q;
    logic              rsp_mis_q;
    logic [N_BITS-1:0] rsp_data_q;
    logic [N_BITS-1:0] rsp_data_d;

    logic              accept;
    logic              kill_now;
    logic              op_misalign;
    logic [3:0]        fmt_be;
    logic [N_BITS-1:0] fmt_wdata;
    logic [N_BITS-1:0] fmt_rdata;

    assign op_d = '{wr:    op_wr,
                    size:  mem_size_t'(op_size),
                    uns:   op_unsigned,
                    addr:  op_addr,
                    wdata: op_wdata};

    assign accept = (state_q == ST_IDLE) && op_vld && !squash_in;

    // A squash arriving in the completing cycle still suppresses the response.
    assign kill_now = kill_q | squash_in;

`ifdef DMEM_MISALIGN_CHK_EN
    assign op_misalign = is_misaligned(op_d.size, op_d.addr[1:0]);
`else
    assign op_misalign = 1'b0;
`endif

    // Lane logic always works on the captured op, so request fields stay
    // stable while the controller waits for dmem_req_rdy.
    dmem_access_ctrl_lane_fmt u_lane_fmt (
        .size_i    (op_q.size),
        .uns_i     (op_q.uns),
        .addr_lo_i (op_q.addr[1:0]),
        .wdata_i   (op_q.wdata),
        .rdata_i   (dmem.dmem_rsp_data),
        .be_o      (fmt_be),
        .wdata_o   (fmt_wdata),
        .rdata_o   (fmt_rdata)
    );

    assign rsp_data_d = (op_q.wr || kill_now) ? '0 : fmt_rdata;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            kill_q     <= 1'b0;
            cnt_q      <= '0;
            req_vld_q  <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_mis_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            // Response outputs are single-cycle: cleared unless entering RESP.
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_mis_q  <= 1'b0;
            rsp_data_q <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= op_d;
                        kill_q <= 1'b0;
                        if (op_misalign) begin
                            state_q   <= ST_RESP;
                            rsp_vld_q <= 1'b1;
                            rsp_err_q <= 1'b1;
                            rsp_mis_q <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ;
                            req_vld_q <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    // Valid is held even when squashed; only the response is hidden.
                    if (squash_in) kill_q <= 1'b1;
                    if (dmem.dmem_req_rdy) begin
                        state_q   <= ST_WAIT;
                        req_vld_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end

                ST_WAIT: begin
                    if (squash_in) kill_q <= 1'b1;
                    // A response in the timeout cycle takes priority.
                    if (dmem.dmem_rsp_vld) begin
                        state_q    <= ST_RESP;
                        rsp_vld_q  <= !kill_now;
                        rsp_data_q <= rsp_data_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_RESP;
                        rsp_vld_q <= !kill_now;
                        rsp_err_q <= !kill_now;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                    kill_q  <= 1'b0;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_rdy = (state_q == ST_IDLE);
    assign stall  = accept || (state_q == ST_REQ) || (state_q == ST_WAIT);

    assign dmem.dmem_req_vld   = req_vld_q;
    assign dmem.dmem_req_we    = req_vld_q & op_q.wr;
    assign dmem.dmem_req_addr  = req_vld_q ? {op_q.addr[N_BITS-1:2], 2'b00} : '0;
    assign dmem.dmem_req_be    = req_vld_q ? fmt_be : 4'b0000;
    assign dmem.dmem_req_wdata = req_vld_q ? fmt_wdata : '0;

    assign rsp_vld      = rsp_vld_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_misalign = rsp_mis_q;

endmodule
